// File: rtl/instr_sequencer_if.sv
// Instruction-sequencer bus: start/status, instruction-fetch handshake and the
// decoded control lines driven toward the register file and ALU.
interface instr_sequencer_if #(
    parameter int PC_W = 16
);
    logic            start;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic [5:0]      rf_ra_a;
    logic [5:0]      rf_ra_b;
    logic [3:0]      alu_fx;
    logic            alu_b_sel;
    logic [31:0]     imm_ext;
    logic            wb_en;
    logic [5:0]      wb_addr;
    logic            busy;
    logic            halted;

    modport master (
        input  start, imem_ack, imem_rdata,
        output imem_req, imem_addr, rf_ra_a, rf_ra_b, alu_fx, alu_b_sel,
               imm_ext, wb_en, wb_addr, busy, halted
    );

    modport slave (
        output start, imem_ack, imem_rdata,
        input  imem_req, imem_addr, rf_ra_a, rf_ra_b, alu_fx, alu_b_sel,
               imm_ext, wb_en, wb_addr, busy, halted
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/exec/writeback sequencer that owns the program counter.
// Optional SEQ_R0_ZERO_EN: suppress the writeback strobe when rd is register 0.
module instr_sequencer #(
    parameter int PC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    instr_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [31:0]        ir_q, ir_d;
    logic [5:0]         ra_a_q, ra_a_d;
    logic [5:0]         ra_b_q, ra_b_d;
    logic [5:0]         wb_addr_q, wb_addr_d;
    logic [3:0]         fx_q, fx_d;
    logic               b_sel_q, b_sel_d;
    logic signed [31:0] imm_q, imm_d;
    logic               is_halt;

    // I-type carries a 15-bit immediate, R-type only 9 bits below the rt field.
    function automatic logic signed [31:0] sext_imm(input logic [31:0] ir);
        logic signed [31:0] r;
        if (ir[31]) r = {{17{ir[14]}}, ir[14:0]};
        else        r = {{23{ir[8]}}, ir[8:0]};
        return r;
    endfunction

    assign is_halt = !ir_q[31] && (ir_q[18:15] == 4'hF);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        ra_a_d        = ra_a_q;
        ra_b_d        = ra_b_q;
        wb_addr_d     = wb_addr_q;
        fx_d          = fx_q;
        b_sel_d       = b_sel_q;
        imm_d         = imm_q;
        bus.imem_req  = 1'b0;
        bus.busy      = 1'b1;
        bus.halted    = 1'b0;
        bus.wb_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_d = S_FETCH;
            end
            S_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_halt) begin
                    state_d = S_HALTED;
                end else begin
                    // Decoded fields are captured only on the way into EXEC.
                    state_d   = S_EXEC;
                    ra_a_d    = ir_q[30:25];
                    wb_addr_d = ir_q[24:19];
                    fx_d      = ir_q[18:15];
                    ra_b_d    = ir_q[31] ? 6'd0 : ir_q[14:9];
                    b_sel_d   = ir_q[31];
                    imm_d     = sext_imm(ir_q);
                end
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
`ifdef SEQ_R0_ZERO_EN
                bus.wb_en = (wb_addr_q != 6'd0);
`else
                bus.wb_en = 1'b1;
`endif
                pc_d    = pc_q + PC_W'(1);
                state_d = S_FETCH;
            end
            S_HALTED: begin
                bus.busy   = 1'b0;
                bus.halted = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            ra_a_q    <= '0;
            ra_b_q    <= '0;
            wb_addr_q <= '0;
            fx_q      <= '0;
            b_sel_q   <= 1'b0;
            imm_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            ra_a_q    <= ra_a_d;
            ra_b_q    <= ra_b_d;
            wb_addr_q <= wb_addr_d;
            fx_q      <= fx_d;
            b_sel_q   <= b_sel_d;
            imm_q     <= imm_d;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.rf_ra_a   = ra_a_q;
    assign bus.rf_ra_b   = ra_b_q;
    assign bus.alu_fx    = fx_q;
    assign bus.alu_b_sel = b_sel_q;
    assign bus.imm_ext   = imm_q;
    assign bus.wb_addr   = wb_addr_q;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control FSM for the 32-bit processor. It fetches instruction words over a request/acknowledge handshake and decodes the RI/rs/rd/fx/rt/imm fields. It then drives register-file read addresses, ALU function and operand-B select, and a one-cycle writeback strobe. It sits between instruction memory and the register file/ALU datapath and owns the program counter.

## Interface
- PC_W, 16, program counter / instruction address width (word-addressed)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  leave IDLE and begin fetching at current PC
- imem_req  out  1  fetch request, high throughout FETCH
- imem_addr  out  PC_W  current PC
- imem_ack  in  1  instruction word valid this cycle
- imem_rdata  in  32  instruction word
- rf_ra_a  out  6  register read address A (rs)
- rf_ra_b  out  6  register read address B (rt; 0 for I-type)
- alu_fx  out  4  ALU function code
- alu_b_sel  out  1  1 = operand B from imm_ext, 0 = register B
- imm_ext  out  32  sign-extended immediate
- wb_en  out  1  register write strobe, one cycle
- wb_addr  out  6  register write address (rd)
- busy  out  1  high in any state other than IDLE and HALTED
- halted  out  1  high in HALTED

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALTED.
- Transitions:
  - IDLE -> FETCH on start.
  - FETCH -> DECODE on imem_ack; the word is latched into the instruction register (IR).
  - DECODE -> HALTED if IR[31]=0 and IR[18:15]=4'hF; otherwise DECODE -> EXEC.
  - EXEC -> WB.
  - WB -> FETCH, with PC <= PC+1.
  - HALTED is held until rst.
- Decode, from IR:
  - RI = IR[31] (1 = I-type).
  - rs = IR[30:25], rd = IR[24:19], fx = IR[18:15].
  - rt = IR[14:9] for R-type, 6'd0 for I-type.
  - imm = IR[14:0] for I-type, IR[8:0] for R-type, sign-extended to 32 bits from its top bit.
- Decode outputs (rf_ra_a, rf_ra_b, alu_fx, alu_b_sel=RI, imm_ext, wb_addr) are registered. They update on entry to EXEC and hold through WB.
- wb_en is high exactly in WB.
- PC is PC_W bits and wraps from all-ones to 0 with no flag.
- start is ignored outside IDLE.
- imem_ack is ignored outside FETCH.
- FETCH waits indefinitely; imem_req stays high until ack.

## Timing
- Reset values:
  - State IDLE; PC=0; IR=0.
  - imem_req=0, imem_addr=0, rf_ra_a=0, rf_ra_b=0, alu_fx=0, alu_b_sel=0, imm_ext=0, wb_en=0, wb_addr=0, busy=0, halted=0.
- rst has priority over every transition. Reset mid-FETCH drops imem_req the next cycle, and an ack arriving in that cycle is discarded.
- Minimum instruction latency is 4 cycles, with ack in the first FETCH cycle: FETCH, DECODE, EXEC, WB. Each cycle of ack delay adds one cycle.
- imem_req and imem_addr are valid in the same cycle FETCH is entered. imem_addr is stable while imem_req is high.
- Decoded outputs are valid from the first EXEC cycle; the ALU and register file read are combinational within EXEC.
- The PC increment is visible on imem_addr in the FETCH cycle following WB.
- A halt instruction produces no EXEC, no WB, and no PC increment; halted rises one cycle after DECODE.

## Configuration
- SEQ_R0_ZERO_EN:
  - Defined: wb_en is suppressed when rd=0, so register 0 is never written. The WB state is still traversed and the PC still increments.
  - Undefined: rd=0 is written like any other register.

## Test plan
- Reset, start=1, ack in first FETCH cycle with rdata=0x02118800 -> in EXEC: rf_ra_a=1, rf_ra_b=4, alu_fx=3, alu_b_sel=0, imm_ext=0; in WB: wb_en=1, wb_addr=2; next fetch has imem_addr=1.
- I-type rdata=0x8A317FFF -> rf_ra_a=5, rf_ra_b=0, wb_addr=6, alu_fx=2, alu_b_sel=1, imm_ext=0xFFFFFFFF. Then R-type with IR[8:0]=0x0FF -> imm_ext=0x000000FF; IR[8:0]=0x100 -> imm_ext=0xFFFFFF00.
- Ack delayed 3 cycles -> imem_req high 4 cycles with constant imem_addr, wb_en exactly one cycle, total 7 cycles. Ack pulsed during EXEC -> no effect.
- Halt word 0x00078000 at PC=2 -> halted=1, busy=0, imem_addr stays 2, no wb_en. A later start pulse -> no change.
- rst asserted mid-FETCH with simultaneous ack -> next cycle IDLE, PC=0, all outputs 0. With PC_W=2, four non-halt instructions from PC=3 -> PC sequence 3,0,1,2.
- Write to rd=0: with SEQ_R0_ZERO_EN defined -> wb_en stays 0; undefined -> wb_en=1, wb_addr=0.
